// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared constants for the seven-segment display demultiplexer.
//   IDLE_AN      : anode bus value meaning "no digit driven" (active-low)
//   BLANK_SEG    : all segments and dp off (active-low)
//   NUM_DIGITS   : digit positions on the multiplexed bus
//   GLYPH_TABLE  : entry i is the active-low {a,b,c,d,e,f,g} pattern of hex i,
//                  the same encoding the codebase hex_to_sseg produces
//   is_one_hot_low() : exactly one anode line pulled low
// -----------------------------------------------------------------------------
package disp_pkg;

    localparam logic [3:0] IDLE_AN    = 4'b1111;
    localparam logic [7:0] BLANK_SEG  = 8'hFF;
    localparam int         NUM_DIGITS = 4;

    // Packed so that GLYPH_TABLE[i] is the glyph of hex digit i.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic is_one_hot_low(input logic [3:0] an);
        logic [3:0] act;
        act = ~an;
        return (act != 4'b0000) && ((act & (act - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/sseg_to_hex.sv
// -----------------------------------------------------------------------------
// sseg_to_hex
// Combinational reverse lookup of a seven-segment glyph.
//   pattern_i [6:0] : active-low {a,b,c,d,e,f,g}
//   hex_o     [3:0] : hex value of the matching glyph, 4'h0 when unmatched
//   match_o         : pattern is one of the 16 hex glyphs
// -----------------------------------------------------------------------------
module sseg_to_hex
    import disp_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] hex_o,
    output logic       match_o
);

    always_comb begin
        // NOTE: every output gets a default before the search loop; otherwise
        // an unmatched pattern would leave them unassigned and infer a latch.
        hex_o   = 4'h0;
        match_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == GLYPH_TABLE[i]) begin
                hex_o   = 4'(i);
                match_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/disp_demux.sv
// -----------------------------------------------------------------------------
// disp_demux
// Recovers the four digit patterns from a time-multiplexed seven-segment bus.
// A digit is captured once its anode/segment sample has been steady for
// STABLE_CYCLES registered samples; four distinct captures form a frame.
//   clk, reset_n        : clock, synchronous active-low reset
//   an   [3:0]          : anode bus, active-low one-hot, 4'b1111 = idle
//   sseg [7:0]          : segment bus, active-low, [7]=dp, [6:0]={a..g}
//   seg0..seg3 [7:0]    : last captured pattern per digit
//   hex0..hex3 [3:0]    : decoded hex value of seg0..seg3
//   valid [3:0]         : seg_i[6:0] is a hex glyph
//   blank [3:0]         : seg_i[6:0] has all segments off
//   frame_tick          : one-cycle pulse when all four digits were captured
//   err                 : sticky, a steady multi-hot anode pattern was seen
//   stale               : no frame for TIMEOUT_CYCLES cycles
// Build option: define DISP_DEMUX_DECODE_EN to instantiate the glyph decoders;
// without it hex0..hex3 and valid are tied to zero.
// -----------------------------------------------------------------------------
module disp_demux
    import disp_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] an,
    input  logic [7:0] sseg,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic [3:0] hex3,
    output logic [3:0] valid,
    output logic [3:0] blank,
    output logic       frame_tick,
    output logic       err,
    output logic       stale
);

    localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]      CAPTURE_AT  = 8'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [3:0]    an_q;
    logic [7:0]    sseg_q;
    logic [7:0]    stab_cnt_q, stab_cnt_d;
    logic          captured_q, captured_d;
    logic [7:0]    seg_q [NUM_DIGITS];
    logic [7:0]    seg_d [NUM_DIGITS];
    logic [3:0]    seen_q, seen_d;
    logic          frame_tick_q, frame_tick_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic          same_sample;
    logic          window_done;
    logic          capture;
    logic          bad_anode;
    logic [3:0]    seen_set;

    always_comb begin
        same_sample = (an == an_q) && (sseg == sseg_q);
        // The registered sample has been steady for STABLE_CYCLES samples and
        // this window has not been consumed yet.
        window_done = (stab_cnt_q == CAPTURE_AT) && !captured_q;
        capture     = window_done && is_one_hot_low(an_q);
        bad_anode   = window_done && (an_q != IDLE_AN) && !is_one_hot_low(an_q);

        if (same_sample) begin
            stab_cnt_d = (stab_cnt_q == STABLE_MAX) ? stab_cnt_q : stab_cnt_q + 8'd1;
            captured_d = captured_q | window_done;
        end else begin
            // Any change opens a new window, even if this edge also captures.
            stab_cnt_d = 8'd0;
            captured_d = 1'b0;
        end

        seg_d = seg_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && !an_q[i]) seg_d[i] = sseg_q;
        end

        seen_set     = capture ? (seen_q | ~an_q) : seen_q;
        frame_tick_d = capture && (seen_set == 4'b1111);
        seen_d       = frame_tick_d ? 4'b0000 : seen_set;
        err_d        = err_q | bad_anode;

        if (frame_tick_d)                 tmo_cnt_d = '0;
        else if (tmo_cnt_q == TIMEOUT_MAX) tmo_cnt_d = tmo_cnt_q;
        else                              tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            an_q         <= IDLE_AN;
            sseg_q       <= BLANK_SEG;
            stab_cnt_q   <= 8'd0;
            captured_q   <= 1'b0;
            seen_q       <= 4'b0000;
            frame_tick_q <= 1'b0;
            err_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            // NOTE: the digit array is a handful of flops, not a RAM, and must
            // read blank out of reset, so it is reset like any other register.
            for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= BLANK_SEG;
        end else begin
            an_q         <= an;
            sseg_q       <= sseg;
            stab_cnt_q   <= stab_cnt_d;
            captured_q   <= captured_d;
            seen_q       <= seen_d;
            frame_tick_q <= frame_tick_d;
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            seg_q        <= seg_d;
        end
    end

    assign seg0       = seg_q[0];
    assign seg1       = seg_q[1];
    assign seg2       = seg_q[2];
    assign seg3       = seg_q[3];
    assign frame_tick = frame_tick_q;
    assign err        = err_q;
    assign stale      = (tmo_cnt_q == TIMEOUT_MAX);

    always_comb begin
        blank = 4'b0000;
        for (int i = 0; i < NUM_DIGITS; i++) blank[i] = (seg_q[i][6:0] == 7'h7F);
    end

`ifdef DISP_DEMUX_DECODE_EN
    logic [3:0] hex_w   [NUM_DIGITS];
    logic [3:0] match_w;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        // dp (bit 7) is stored but never decoded.
        sseg_to_hex u_dec (
            .pattern_i (seg_q[g][6:0]),
            .hex_o     (hex_w[g]),
            .match_o   (match_w[g])
        );
    end

    assign hex0  = hex_w[0];
    assign hex1  = hex_w[1];
    assign hex2  = hex_w[2];
    assign hex3  = hex_w[3];
    assign valid = match_w;
`else
    assign hex0  = 4'h0;
    assign hex1  = 4'h0;
    assign hex2  = 4'h0;
    assign hex3  = 4'h0;
    assign valid = 4'b0000;
`endif

endmodule

// File: doc/disp_demux.md
DISP_DEMUX -- requirements
Module: disp_demux

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYCLES, default 2**20: cycles without a completed frame before stale asserts.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 an  in  4  multiplexed anode bus, active-low one-hot; 4'b1111 = no digit driven.
REQ-006 sseg  in  8  multiplexed segment bus, active-low; sseg[7]=dp, sseg[6:0]={a,b,c,d,e,f,g}.
REQ-007 seg0..seg3  out  8 each  last captured segment pattern for digit 0..3 (an[i] low).
REQ-008 hex0..hex3  out  4 each  decoded hex value of seg0..seg3.
REQ-009 valid  out  4  valid[i]=1 when seg_i[6:0] matches a hex glyph.
REQ-010 blank  out  4  blank[i]=1 when seg_i[6:0]==7'b1111111.
REQ-011 frame_tick  out  1  one-cycle pulse when all four digits captured since previous pulse.
REQ-012 err  out  1  sticky: stable non-one-hot, non-idle anode pattern seen.
REQ-013 stale  out  1  no frame_tick for TIMEOUT_CYCLES cycles.

Function
REQ-014 an and sseg registered once (an_q, sseg_q) each cycle; all decisions use registered values.
REQ-015 Stability counter increments, saturating at STABLE_CYCLES, while {an,sseg} equals {an_q,sseg_q}; clears to 0 on any difference.
REQ-016 Capture: when counter reaches STABLE_CYCLES-1, an_q one-hot-low, and window not yet captured, seg_i <= sseg_q on that edge; first sample of new value at edge k gives seg_i update at edge k+STABLE_CYCLES.
REQ-017 At most one capture per anode window; window ends on any change of an or sseg; a sseg change within same an re-opens capture for that digit.
REQ-018 an_q==4'b1111 (idle): no capture, no error.
REQ-019 Stable non-one-hot, non-idle an (e.g. 4'b1100) for STABLE_CYCLES samples: err <= 1, no capture.
REQ-020 seen[3:0] sets bit i on capture of digit i; on the capture making seen==4'b1111, frame_tick=1 next cycle and seen clears in same edge.
REQ-021 Digit captured twice before frame completes: seg_i overwritten, seen unchanged.
REQ-022 Timeout counter clears on frame_tick, else increments saturating; stale=1 when count==TIMEOUT_CYCLES; stale clears with frame_tick.
REQ-023 hex/valid/blank combinational from seg registers; no added latency.
REQ-024 Glyph table identical to codebase hex_to_sseg encoding (0=7'b0000001 ... F=7'b0111000); unmatched pattern: hex_i=4'h0, valid[i]=0.
REQ-025 dp bit stored in seg_i[7], ignored by decode.

Reset
REQ-026 reset_n low at clk edge: seg0..seg3=8'hFF, hex=0, valid=0, blank=4'b1111, frame_tick=0, err=0, stale=0, seen=0, counters=0, an_q=4'b1111, sseg_q=8'hFF.
REQ-027 Reset mid-window discards partial stability count; capture requires full STABLE_CYCLES after release.

Configuration
REQ-028 Macro DISP_DEMUX_DECODE_EN: defined -> decoder per REQ-023/024 instantiated; undefined -> hex0..hex3 tied 4'h0, valid tied 4'b0000, blank and all other behaviour unchanged.

Structure
REQ-029 Shared package disp_pkg: 16-entry glyph constant table, IDLE_AN=4'b1111, BLANK_SEG=8'hFF.
REQ-030 One combinational sub-module sseg_to_hex (7-bit pattern -> 4-bit hex + match), instantiated four times under DISP_DEMUX_DECODE_EN.

Verification
REQ-031 STABLE_CYCLES=4; an=4'b1110, sseg=8'b10000001 held 10 cycles -> seg0=8'h81 exactly 4 edges after first sample, hex0=0, valid[0]=1, one capture only.
REQ-032 Cycle an 1110/1101/1011/0111, 16 cycles each, sseg=glyphs 1,2,3,F -> frame_tick one pulse per full cycle, hex3..0=F,3,2,1.
REQ-033 Glitch: sseg changes every 2 cycles under an=4'b1101 -> no capture, seg1 stays 8'hFF.
REQ-034 an=4'b1100 stable 5 cycles -> err=1 and stays 1 until reset_n low.
REQ-035 TIMEOUT_CYCLES=100, no anode activity -> stale=1 at cycle 100; next complete frame -> stale=0 with frame_tick.
REQ-036 Digit 3 sseg=8'hFF -> blank[3]=1, valid[3]=0; build without DISP_DEMUX_DECODE_EN -> hex=0, valid=0, seg/blank unchanged.
